// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared size masks, state encoding and alignment helpers for the memory stage
package mem_access_pkg;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Any lane above the half lanes means word, any above byte means half.
  function automatic size_t mask_size(input logic [3:0] m);
    if ((m & MASK_WORD & ~MASK_HALF) != 4'd0) return SZ_WORD;
    if ((m & ~MASK_BYTE) != 4'd0) return SZ_HALF;
    return SZ_BYTE;
  endfunction

  function automatic logic misaligned(input logic [3:0] m, input logic [1:0] off);
    case (mask_size(m))
      SZ_WORD: return off != 2'b00;
      SZ_HALF: return off[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-enable and store-lane replication, load shift and sign/zero extension
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  i_acc_mask,
  input  logic [1:0]  i_acc_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [3:0]  i_ld_mask,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_sext,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;

  assign o_be = i_acc_mask << i_acc_off;

  always_comb begin
    o_wdata = i_st_data;
    case (mask_size(i_acc_mask))
      SZ_HALF: o_wdata = {2{i_st_data[15:0]}};
      SZ_BYTE: o_wdata = {4{i_st_data[7:0]}};
      default: o_wdata = i_st_data;
    endcase
  end

  assign w_shifted = i_ld_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld_data = w_shifted;
    case (mask_size(i_ld_mask))
      SZ_BYTE: o_ld_data = {{24{i_ld_sext & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_ld_data = {{16{i_ld_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32 memory stage: load/store over a req/ack data bus, ALU forwarding, stall and timeout
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_x_rd_vld,
  input  logic [31:0] EX_x_rd,
  input  logic [4:0]  EX_rd_idx,
  input  logic [31:0] EX_MEMaddr,
  input  logic [3:0]  EX_MEMrden,
  input  logic        EX_MEMrden_SEXT,
  input  logic [3:0]  EX_MEMwren,
  input  logic [31:0] EX_MEMwrdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        MEM_x_rd_vld,
  output logic [31:0] MEM_x_rd,
  output logic [4:0]  MEM_rd_idx,
  output logic        MEM_stall,
  output logic        MEM_misalign,
  output logic        MEM_bus_err
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic [4:0]         r_rd_idx;
  logic [3:0]         r_ld_mask;
  logic [1:0]         r_ld_off;
  logic               r_ld_sext;
  logic               r_x_rd_vld;
  logic [31:0]        r_x_rd;
  logic [4:0]         r_wb_idx;
  logic               r_misalign;
  logic               r_bus_err;

  logic               w_wr;
  logic               w_mem;
  logic [3:0]         w_mask;
  logic               w_misalign;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_ld_data;
  logic               w_timeout;

  // A write wins when both masks are set; the read mask is then ignored.
  assign w_wr       = EX_MEMwren != 4'd0;
  assign w_mem      = w_wr || (EX_MEMrden != 4'd0);
  assign w_mask     = w_wr ? EX_MEMwren : EX_MEMrden;
  assign w_misalign = misaligned(w_mask, EX_MEMaddr[1:0]);
  assign w_timeout  = r_cnt == CNT_W'(TIMEOUT_CYC - 1);

  mem_lane_align u_align (
    .i_acc_mask (w_mask),
    .i_acc_off  (EX_MEMaddr[1:0]),
    .i_st_data  (EX_MEMwrdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_mask  (r_ld_mask),
    .i_ld_off   (r_ld_off),
    .i_ld_sext  (r_ld_sext),
    .i_ld_rdata (dbus_rdata),
    .o_ld_data  (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_rd_idx   <= '0;
      r_ld_mask  <= '0;
      r_ld_off   <= '0;
      r_ld_sext  <= 1'b0;
      r_x_rd_vld <= 1'b0;
      r_x_rd     <= '0;
      r_wb_idx   <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_x_rd_vld <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_mem) begin
            if (w_misalign) begin
              r_misalign <= 1'b1;
            end else begin
              r_state   <= ST_REQ;
              r_cnt     <= '0;
              r_req     <= 1'b1;
              r_we      <= w_wr;
              r_addr    <= {EX_MEMaddr[31:2], 2'b00};
              r_be      <= w_be;
              r_wdata   <= w_wdata;
              r_rd_idx  <= EX_rd_idx;
              r_ld_mask <= EX_MEMrden;
              r_ld_off  <= EX_MEMaddr[1:0];
              r_ld_sext <= EX_MEMrden_SEXT;
            end
          end else if (EX_x_rd_vld) begin
            r_x_rd_vld <= 1'b1;
            r_x_rd     <= EX_x_rd;
            r_wb_idx   <= EX_rd_idx;
          end
        end
        ST_REQ: begin
          // An ack in the last allowed cycle still completes the transfer.
          if (dbus_ack) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            if (!r_we) begin
              r_x_rd_vld <= 1'b1;
              r_x_rd     <= w_ld_data;
              r_wb_idx   <= r_rd_idx;
            end
          end else if (w_timeout) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dbus_req     = r_req;
  assign dbus_we      = r_we;
  assign dbus_addr    = r_addr;
  assign dbus_be      = r_be;
  assign dbus_wdata   = r_wdata;
  assign MEM_x_rd_vld = r_x_rd_vld;
  assign MEM_x_rd     = r_x_rd;
  assign MEM_rd_idx   = r_wb_idx;
  assign MEM_stall    = r_state == ST_REQ;
  assign MEM_misalign = r_misalign;
  assign MEM_bus_err  = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access with directed and randomized accesses
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_x_rd_vld;
  logic [31:0] EX_x_rd;
  logic [4:0]  EX_rd_idx;
  logic [31:0] EX_MEMaddr;
  logic [3:0]  EX_MEMrden;
  logic        EX_MEMrden_SEXT;
  logic [3:0]  EX_MEMwren;
  logic [31:0] EX_MEMwrdata;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        MEM_x_rd_vld;
  logic [31:0] MEM_x_rd;
  logic [4:0]  MEM_rd_idx;
  logic        MEM_stall;
  logic        MEM_misalign;
  logic        MEM_bus_err;

  int n_pass = 0;
  int n_total = 0;

  mem_access #(.TIMEOUT_CYC(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .EX_x_rd_vld(EX_x_rd_vld), .EX_x_rd(EX_x_rd), .EX_rd_idx(EX_rd_idx),
    .EX_MEMaddr(EX_MEMaddr), .EX_MEMrden(EX_MEMrden), .EX_MEMrden_SEXT(EX_MEMrden_SEXT),
    .EX_MEMwren(EX_MEMwren), .EX_MEMwrdata(EX_MEMwrdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .MEM_x_rd_vld(MEM_x_rd_vld), .MEM_x_rd(MEM_x_rd), .MEM_rd_idx(MEM_rd_idx),
    .MEM_stall(MEM_stall), .MEM_misalign(MEM_misalign), .MEM_bus_err(MEM_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    EX_x_rd_vld = 0; EX_x_rd = '0; EX_rd_idx = '0; EX_MEMaddr = '0;
    EX_MEMrden = '0; EX_MEMrden_SEXT = 0; EX_MEMwren = '0; EX_MEMwrdata = '0;
  endtask

  task automatic junk_ex();
    EX_x_rd_vld = 1'($urandom); EX_x_rd = $urandom; EX_rd_idx = 5'($urandom);
    EX_MEMaddr = $urandom; EX_MEMrden = 4'($urandom); EX_MEMrden_SEXT = 1'($urandom);
    EX_MEMwren = 4'($urandom); EX_MEMwrdata = $urandom;
  endtask

  // Reference model: access of nb bytes at byte address a on a little-endian 32-bit bus.
  function automatic logic [3:0] m_be(input int nb, input logic [31:0] a);
    logic [7:0] b;
    b = 8'(((1 << nb) - 1) << (a % 4));
    return b[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int nb, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input int nb, input logic [31:0] a,
                                         input logic [31:0] rd, input bit sx);
    longint unsigned s, m, v;
    s = longint'(rd) >> (8 * (a % 4));
    m = 64'd1 << (8 * nb);
    v = s % m;
    if (sx && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  task automatic do_alu(input logic [31:0] val, input logic [4:0] idx);
    EX_x_rd_vld = 1; EX_x_rd = val; EX_rd_idx = idx;
    tick();
    clr_ex();
    chk("alu_vld", 32'(MEM_x_rd_vld), 1);
    chk("alu_data", MEM_x_rd, val);
    chk("alu_idx", 32'(MEM_rd_idx), 32'(idx));
    chk("alu_noreq", 32'(dbus_req), 0);
    tick();
    chk("alu_pulse_end", 32'(MEM_x_rd_vld), 0);
  endtask

  task automatic do_mem(input bit wr, input int nb, input logic [31:0] a, input logic [31:0] d,
                        input bit sx, input int ack_at, input logic [31:0] rd, input bit both);
    logic [3:0] mask;
    logic [4:0] idx;
    bit done;
    mask = 4'((1 << nb) - 1);
    idx = 5'($urandom);
    EX_MEMaddr = a; EX_rd_idx = idx; EX_MEMrden_SEXT = sx;
    EX_x_rd_vld = 1'($urandom); EX_x_rd = $urandom;
    if (wr) begin
      EX_MEMwren = mask; EX_MEMwrdata = d; EX_MEMrden = both ? 4'hF : 4'h0;
    end else begin
      EX_MEMrden = mask;
    end
    tick();
    clr_ex();
    if (a % nb != 0) begin
      chk("mis_pulse", 32'(MEM_misalign), 1);
      chk("mis_noreq", 32'(dbus_req), 0);
      chk("mis_nowb", 32'(MEM_x_rd_vld), 0);
      chk("mis_nostall", 32'(MEM_stall), 0);
      tick();
      chk("mis_pulse_end", 32'(MEM_misalign), 0);
      return;
    end
    chk("req", 32'(dbus_req), 1);
    chk("stall", 32'(MEM_stall), 1);
    chk("we", 32'(dbus_we), 32'(wr));
    chk("addr", dbus_addr, a & 32'hFFFF_FFFC);
    chk("be", 32'(dbus_be), 32'(m_be(nb, a)));
    if (wr) chk("wdata", dbus_wdata, m_wdata(nb, d));
    done = 0;
    for (int c = 0; c < TO && !done; c++) begin
      junk_ex();
      if (c == ack_at) begin dbus_ack = 1; dbus_rdata = rd; end
      tick();
      clr_ex();
      dbus_ack = 0; dbus_rdata = $urandom;
      if (c == ack_at) begin
        done = 1;
        chk("ack_req_drop", 32'(dbus_req), 0);
        chk("ack_stall_drop", 32'(MEM_stall), 0);
        chk("ack_no_err", 32'(MEM_bus_err), 0);
        chk("ack_wb_vld", 32'(MEM_x_rd_vld), 32'(!wr));
        if (!wr) begin
          chk("load_data", MEM_x_rd, m_load(nb, a, rd, sx));
          chk("load_idx", 32'(MEM_rd_idx), 32'(idx));
        end
      end else if (c == TO - 1) begin
        done = 1;
        chk("to_err", 32'(MEM_bus_err), 1);
        chk("to_req_drop", 32'(dbus_req), 0);
        chk("to_nowb", 32'(MEM_x_rd_vld), 0);
        chk("to_stall_drop", 32'(MEM_stall), 0);
      end else begin
        chk("hold_req", 32'(dbus_req), 1);
        chk("hold_addr", dbus_addr, a & 32'hFFFF_FFFC);
        chk("hold_be", 32'(dbus_be), 32'(m_be(nb, a)));
        if (wr) chk("hold_wdata", dbus_wdata, m_wdata(nb, d));
      end
    end
    tick();
    chk("pulses_clear", {29'd0, MEM_x_rd_vld, MEM_bus_err, MEM_misalign}, 0);
  endtask

  initial begin
    int sizes[3];
    sizes = '{1, 2, 4};
    clr_ex();
    dbus_ack = 0; dbus_rdata = '0;
    rst = 1;
    tick(); tick();
    chk("rst_req", 32'(dbus_req), 0);
    chk("rst_outs", {dbus_we, dbus_be, MEM_x_rd_vld, MEM_stall, MEM_misalign, MEM_bus_err}, 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_xrd", MEM_x_rd, 0);
    rst = 0;
    tick();

    do_alu(32'h1234_5678, 5'd5);
    do_mem(0, 1, 32'h103, 0, 1, 0, 32'h80FF_0011, 0);
    do_mem(0, 2, 32'h22, 0, 0, 0, 32'hBEEF_1234, 0);
    do_mem(1, 1, 32'h41, 32'hAB, 0, 3, 0, 0);
    do_mem(1, 4, 32'h80, 32'hCAFE_F00D, 0, 1, 0, 1);
    do_mem(0, 4, 32'h102, 0, 0, 0, 0, 0);
    do_mem(0, 4, 32'h200, 0, 0, TO, 32'h1111_1111, 0);

    // Reset in the second REQ cycle of a pending load.
    EX_MEMaddr = 32'h300; EX_MEMrden = 4'hF; EX_rd_idx = 5'd7;
    tick();
    clr_ex();
    chk("rst_mid_req1", 32'(dbus_req), 1);
    tick();
    chk("rst_mid_req2", 32'(dbus_req), 1);
    rst = 1; dbus_ack = 1; dbus_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 0; dbus_ack = 0;
    chk("rst_mid_drop", 32'(dbus_req), 0);
    chk("rst_mid_pulses", {29'd0, MEM_x_rd_vld, MEM_bus_err, MEM_misalign}, 0);
    chk("rst_mid_stall", 32'(MEM_stall), 0);
    tick();

    for (int i = 0; i < 60; i++) begin
      int nb;
      nb = sizes[$urandom_range(0, 2)];
      case ($urandom_range(0, 3))
        0: do_alu($urandom, 5'($urandom));
        1: do_mem(0, nb, $urandom, 0, 1'($urandom), $urandom_range(0, TO), $urandom, 0);
        2: do_mem(1, nb, $urandom, $urandom, 0, $urandom_range(0, TO), 0, 1'($urandom));
        default: do_mem(0, nb, $urandom & 32'hFFFF_FFFC | 32'($urandom_range(0, 3)),
                        0, 1'($urandom), $urandom_range(0, TO - 1), $urandom, 0);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
